// File: rtl/invaders_video_scan.sv
// invaders_video_scan
//   Raster scan generator for a 1bpp bitmap display. Counts pixels (h) and
//   lines (v), pre-fetches one video RAM byte per 8-pixel column, shifts
//   it out as a monochrome pixel and produces sync/blank timing, a colour
//   lookup address and two CPU interrupt requests (mid-screen, vblank).
//
// Ports
//   Clock       system clock, all logic on its rising edge
//   Reset       synchronous, active-high
//   Pix_Ce      pixel clock enable (never high on two consecutive clocks)
//   Vid_Addr    video RAM read address
//   Vid_Rd      one-clock read strobe, Vid_Addr valid
//   Vid_Data    RAM read data, valid the clock after Vid_Rd
//   Pixel       monochrome pixel, one pixel of latency
//   Color_Addr  colour PROM address {0, v[7:3], h[7:3]}
//   HSync, VSync, HBlank, VBlank   raster timing, registered with Pixel
//   Int_Mid, Int_VBl               one-clock interrupt requests
//   HCount, VCount                 current h and v
//
// V_ACTIVE (visible lines) and V_MID (mid-screen interrupt line) default to
// the standard raster; they are exposed so a shortened frame can be built.
module invaders_video_scan #(
  parameter int          H_TOTAL   = 320,
  parameter int          V_TOTAL   = 262,
  parameter int          HS_START  = 272,
  parameter int          HS_END    = 303,
  parameter int          VS_START  = 236,
  parameter int          VS_END    = 239,
  parameter logic [15:0] VRAM_BASE = 16'h2400,
  parameter int          V_ACTIVE  = 224,
  parameter int          V_MID     = 96
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Pix_Ce,
  output logic [15:0] Vid_Addr,
  output logic        Vid_Rd,
  input  logic [7:0]  Vid_Data,
  output logic        Pixel,
  output logic [10:0] Color_Addr,
  output logic        HSync,
  output logic        VSync,
  output logic        HBlank,
  output logic        VBlank,
  output logic        Int_Mid,
  output logic        Int_VBl,
  output logic [8:0]  HCount,
  output logic [8:0]  VCount
);

  localparam logic [8:0] H_LAST    = 9'(H_TOTAL - 1);
  localparam logic [8:0] H_PREF    = 9'(H_TOTAL - 2);
  localparam logic [8:0] V_LAST    = 9'(V_TOTAL - 1);
  localparam logic [8:0] HS_FIRST  = 9'(HS_START);
  localparam logic [8:0] HS_LAST   = 9'(HS_END);
  localparam logic [8:0] VS_FIRST  = 9'(VS_START);
  localparam logic [8:0] VS_LAST   = 9'(VS_END);
  localparam logic [8:0] V_ACT     = 9'(V_ACTIVE);
  localparam logic [8:0] V_MID_PRE = 9'(V_MID - 1);
  localparam logic [8:0] V_ACT_PRE = 9'(V_ACTIVE - 1);
  localparam logic [8:0] H_VIS     = 9'd256;
  localparam logic [8:0] H_FETCH   = 9'd248;

  logic [8:0]  h, v;
  logic [7:0]  prefetch, display;
  logic        capture_pending;

  logic        h_last, v_last;
  logic [8:0]  h_next, v_next;
  logic        col_fetch, line_fetch, col_load, visible;
  logic [7:0]  next_line;
  logic [15:0] fetch_addr;
  logic [7:0]  load_byte;

  always_comb begin
    h_last     = (h == H_LAST);
    v_last     = (v == V_LAST);
    h_next     = h_last ? 9'd0 : h + 9'd1;
    v_next     = v;
    if (h_last) v_next = v_last ? 9'd0 : v + 9'd1;

    col_fetch  = (h[2:0] == 3'd6) && (h < H_FETCH);
    line_fetch = (h == H_PREF);
    col_load   = ((h[2:0] == 3'd7) && (h < H_FETCH)) || h_last;
    visible    = (h < H_VIS) && (v < V_ACT);

    // Line prefetch reads column 0 of the line about to start.
    next_line  = v_last ? 8'd0 : 8'(v + 9'd1);
    if (line_fetch)
      fetch_addr = VRAM_BASE + {3'b000, next_line, 5'b00000};
    else
      fetch_addr = VRAM_BASE + {3'b000, v[7:0], 5'b00000} + {10'd0, h[8:3]} + 16'd1;

    // With the tightest Pix_Ce spacing the load lands on the same edge as
    // the capture, so bypass the prefetch register in that case.
    load_byte  = capture_pending ? Vid_Data : prefetch;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      h               <= '0;
      v               <= '0;
      Vid_Addr        <= VRAM_BASE;
      Vid_Rd          <= 1'b0;
      capture_pending <= 1'b0;
      prefetch        <= '0;
      display         <= '0;
      Pixel           <= 1'b0;
      Color_Addr      <= '0;
      HSync           <= 1'b0;
      VSync           <= 1'b0;
      HBlank          <= 1'b0;
      VBlank          <= 1'b0;
      Int_Mid         <= 1'b0;
      Int_VBl         <= 1'b0;
    end else begin
      Vid_Rd          <= 1'b0;
      Int_Mid         <= 1'b0;
      Int_VBl         <= 1'b0;
      capture_pending <= Vid_Rd;
      if (capture_pending) prefetch <= Vid_Data;

      if (Pix_Ce) begin
        h <= h_next;
        v <= v_next;
        if (col_fetch || line_fetch) begin
          Vid_Addr <= fetch_addr;
          Vid_Rd   <= 1'b1;
        end
        if (col_load) display <= load_byte;
        Pixel      <= visible ? display[h[2:0]] : 1'b0;
        Color_Addr <= {1'b0, v[7:3], h[7:3]};
        HBlank     <= (h >= H_VIS);
        VBlank     <= (v >= V_ACT);
        HSync      <= (h >= HS_FIRST) && (h <= HS_LAST);
        VSync      <= (v >= VS_FIRST) && (v <= VS_LAST);
        Int_Mid    <= h_last && (v == V_MID_PRE);
        Int_VBl    <= h_last && (v == V_ACT_PRE);
      end
    end
  end

  assign HCount = h;
  assign VCount = v;

endmodule

// File: tb/tb_invaders_video_scan.sv
module tb_invaders_video_scan;

  // Shortened frame keeps the run short while exercising every wrap.
  localparam int VT  = 20;
  localparam int VA  = 14;
  localparam int VM  = 6;
  localparam int VSS = 16;
  localparam int VSE = 17;
  localparam int NPIX = 320 * VT;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Pix_Ce = 1'b0;
  logic [15:0] Vid_Addr;
  logic        Vid_Rd;
  logic [7:0]  Vid_Data = 8'h00;
  logic        Pixel;
  logic [10:0] Color_Addr;
  logic        HSync, VSync, HBlank, VBlank, Int_Mid, Int_VBl;
  logic [8:0]  HCount, VCount;

  int n_pass = 0;
  int n_total = 0;
  int mh, mv, ff;
  int rd_cnt, mid_cnt, vbl_cnt;
  logic pix_a [NPIX];

  invaders_video_scan #(
    .V_TOTAL(VT), .VS_START(VSS), .VS_END(VSE), .V_ACTIVE(VA), .V_MID(VM)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Pix_Ce(Pix_Ce),
    .Vid_Addr(Vid_Addr), .Vid_Rd(Vid_Rd), .Vid_Data(Vid_Data),
    .Pixel(Pixel), .Color_Addr(Color_Addr),
    .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
    .Int_Mid(Int_Mid), .Int_VBl(Int_VBl),
    .HCount(HCount), .VCount(VCount)
  );

  always #5 Clock = ~Clock;

  function automatic logic [7:0] ram_byte(input logic [15:0] a);
    logic [7:0] t;
    t = 8'(a[7:0] * 8'd29) + a[12:5];
    return (a == 16'h24A3) ? 8'hA5 : t;
  endfunction

  always @(posedge Clock) if (Vid_Rd) Vid_Data <= ram_byte(Vid_Addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mh = 0; mv = 0; ff = 1;
    rd_cnt = 0; mid_cnt = 0; vbl_cnt = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hcount"}, 32'(HCount), 0);
    chk({tag, "_vcount"}, 32'(VCount), 0);
    chk({tag, "_vid_addr"}, 32'(Vid_Addr), 'h2400);
    chk({tag, "_vid_rd"}, 32'(Vid_Rd), 0);
    chk({tag, "_pixel"}, 32'(Pixel), 0);
    chk({tag, "_color_addr"}, 32'(Color_Addr), 0);
    chk({tag, "_hsync"}, 32'(HSync), 0);
    chk({tag, "_vsync"}, 32'(VSync), 0);
    chk({tag, "_hblank"}, 32'(HBlank), 0);
    chk({tag, "_vblank"}, 32'(VBlank), 0);
    chk({tag, "_int_mid"}, 32'(Int_Mid), 0);
    chk({tag, "_int_vbl"}, 32'(Int_VBl), 0);
  endtask

  // One Pix_Ce pulse followed by 'gap' idle clocks, checked against the model.
  task automatic pix(input int gap);
    int nh, nv, er, ea, ep, col;
    logic [7:0] b;
    er = ((mh % 8) == 6 && mh < 248) || mh == 318;
    if (mh == 318) ea = 'h2400 + ((mv == VT - 1) ? 0 : mv + 1) * 32;
    else           ea = 'h2400 + mv * 32 + mh / 8 + 1;
    col = mh / 8;
    b = (ff != 0 && mv == 0 && col == 0) ? 8'h00 : ram_byte(16'('h2400 + mv * 32 + col));
    ep = (mh < 256 && mv < VA) ? int'(b[mh % 8]) : 0;
    nh = (mh == 319) ? 0 : mh + 1;
    nv = (mh == 319) ? ((mv == VT - 1) ? 0 : mv + 1) : mv;

    Pix_Ce = 1'b1;
    @(posedge Clock); #1;
    Pix_Ce = 1'b0;
    rd_cnt += int'(Vid_Rd); mid_cnt += int'(Int_Mid); vbl_cnt += int'(Int_VBl);
    chk("hcount", 32'(HCount), nh);
    chk("vcount", 32'(VCount), nv);
    chk("vid_rd", 32'(Vid_Rd), er);
    if (er != 0) chk("vid_addr", 32'(Vid_Addr), ea);
    chk("pixel", 32'(Pixel), ep);
    chk("color_addr", 32'(Color_Addr), ((mv / 8) % 32) * 32 + (mh / 8) % 32);
    chk("hblank", 32'(HBlank), int'(mh >= 256));
    chk("vblank", 32'(VBlank), int'(mv >= VA));
    chk("hsync", 32'(HSync), int'(mh >= 272 && mh <= 303));
    chk("vsync", 32'(VSync), int'(mv >= VSS && mv <= VSE));
    chk("int_mid", 32'(Int_Mid), int'(mh == 319 && mv == VM - 1));
    chk("int_vbl", 32'(Int_VBl), int'(mh == 319 && mv == VA - 1));

    for (int i = 0; i < gap; i++) begin
      @(posedge Clock); #1;
      rd_cnt += int'(Vid_Rd); mid_cnt += int'(Int_Mid); vbl_cnt += int'(Int_VBl);
      chk("hold_hcount", 32'(HCount), nh);
    end

    if (mh == 319) begin
      chk("rd_per_line", 32'(rd_cnt), 32);
      rd_cnt = 0;
      if (mv == VT - 1) ff = 0;
    end
    mh = nh; mv = nv;
  endtask

  initial begin
    logic [7:0] a5;
    int ph, pv;
    a5 = 8'b1010_0101;

    // Reset state
    Reset = 1'b1; Pix_Ce = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check_reset_outputs("reset");
    Reset = 1'b0;
    model_reset();

    // Pix_Ce held low: nothing moves
    repeat (6) @(posedge Clock);
    #1;
    chk("idle_hcount", 32'(HCount), 0);
    chk("idle_vid_rd", 32'(Vid_Rd), 0);
    chk("idle_int_mid", 32'(Int_Mid), 0);

    // Frame A: Pix_Ce every second clock
    for (int i = 0; i < NPIX; i++) begin
      ph = mh; pv = mv;
      pix(1);
      pix_a[i] = Pixel;
      if (pv == 5 && ph >= 24 && ph <= 31) begin
        chk("a5_pixel", 32'(Pixel), int'(a5[ph - 24]));
        chk("a5_color_addr", 32'(Color_Addr), 'h003);
      end
      if (ph == 318 && pv == VT - 1) chk("prefetch_wrap_addr", 32'(Vid_Addr), 'h2400);
      if (ph == 318 && pv == 10)     chk("prefetch_v10_addr", 32'(Vid_Addr), 'h2560);
    end
    chk("frameA_wrap_h", 32'(HCount), 0);
    chk("frameA_wrap_v", 32'(VCount), 0);
    chk("frameA_int_mid_count", 32'(mid_cnt), 1);
    chk("frameA_int_vbl_count", 32'(vbl_cnt), 1);

    // Reset one clock after a fetch strobe, mid-line
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    model_reset();
    for (int i = 0; i < 10 * 320 + 150; i++) pix(1);
    chk("pre_reset_h", 32'(HCount), 150);
    pix(1);
    Reset = 1'b1;
    @(posedge Clock); #1;
    check_reset_outputs("midline_reset");
    chk("midline_reset_prefetch", 32'(dut.prefetch), 0);
    chk("midline_reset_display", 32'(dut.display), 0);
    Reset = 1'b0;
    model_reset();

    // Frame B: gaps of 1 and 5 clocks mixed at random
    for (int i = 0; i < NPIX; i++) begin
      pix(($urandom_range(0, 1) == 0) ? 1 : 5);
      chk("pixel_vs_fixed_rate", 32'(Pixel), 32'(pix_a[i]));
    end
    chk("frameB_wrap_h", 32'(HCount), 0);
    chk("frameB_wrap_v", 32'(VCount), 0);
    chk("frameB_int_mid_count", 32'(mid_cnt), 1);
    chk("frameB_int_vbl_count", 32'(vbl_cnt), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/invaders_video_scan.md
INVADERS_VIDEO_SCAN -- requirements
Module: invaders_video_scan

Interface
REQ-001 Parameter H_TOTAL, 320, pixels per line (h = 0..H_TOTAL-1).
REQ-002 Parameter V_TOTAL, 262, lines per frame (v = 0..V_TOTAL-1).
REQ-003 Parameter HS_START, 272, first h with HSync high.
REQ-004 Parameter HS_END, 303, last h with HSync high.
REQ-005 Parameter VS_START, 236, first v with VSync high.
REQ-006 Parameter VS_END, 239, last v with VSync high.
REQ-007 Parameter VRAM_BASE, 16'h2400, video RAM base address.
REQ-008 Clock  in  1  system clock; the block has one clock, all logic on its rising edge.
REQ-009 Reset  in  1  synchronous, active-high reset.
REQ-010 Pix_Ce  in  1  pixel clock enable, never high on two consecutive Clock cycles.
REQ-011 Vid_Addr  out  16  video RAM read address for the RAM port.
REQ-012 Vid_Rd  out  1  one-Clock strobe, Vid_Addr valid.
REQ-013 Vid_Data  in  8  RAM read data, valid the Clock after Vid_Rd.
REQ-014 Pixel  out  1  monochrome pixel.
REQ-015 Color_Addr  out  11  colour PROM/RAM address for the current pixel.
REQ-016 HSync, VSync, HBlank, VBlank  out  1 each  raster timing.
REQ-017 Int_Mid, Int_VBl  out  1 each  one-Clock CPU interrupt requests (RST 1 and RST 2).
REQ-018 HCount, VCount  out  9 each  current counter values h and v.

Function
REQ-019 h increments on each Pix_Ce; at H_TOTAL-1 it wraps to 0 and v increments; at v = V_TOTAL-1 with the h wrap, v wraps to 0.
REQ-020 Counters, fetch and outputs change only on Clock edges with Pix_Ce=1, except Vid_Rd, fetch-data capture and Int_* pulses as stated.
REQ-021 Fetch (issue): on a Pix_Ce with h mod 8 = 6 and h < 248, Vid_Addr = VRAM_BASE + v*32 + (h>>3)+1 and Vid_Rd=1 for that single Clock.
REQ-022 Fetch (line prefetch): on a Pix_Ce with h = H_TOTAL-2, Vid_Addr = VRAM_BASE + v'*32 (column 0), with v' = v+1 or 0 if v = V_TOTAL-1, and Vid_Rd=1.
REQ-023 Fetch arithmetic: 16-bit, line index taken as v[7:0]; no fetch is suppressed during blanking, and addresses above the visible area are legal.
REQ-024 Capture: the Clock after Vid_Rd, Vid_Data is latched into a prefetch register.
REQ-025 Load: on a Pix_Ce with h mod 8 = 7 and h < 248, or with h = H_TOTAL-1, the display byte takes the prefetch register.
REQ-026 Pixel output: on each Pix_Ce with pre-increment counter (h,v) and h<256, v<224, Pixel <= display byte bit (h mod 8), bit 0 leftmost; otherwise Pixel <= 0. One pixel latency.
REQ-027 Color_Addr <= {1'b0, v[7:3], h[7:3]} with the same register timing as Pixel.
REQ-028 HBlank <= (h>=256), VBlank <= (v>=224), HSync <= (HS_START<=h<=HS_END), VSync <= (VS_START<=v<=VS_END), all registered alongside Pixel.
REQ-029 Int_Mid = 1 for exactly one Clock, on the Pix_Ce whose update makes (h,v) = (0,96); Int_VBl likewise for (0,224).
REQ-030 With Pix_Ce held low, all state holds and Vid_Rd and Int_* stay 0.

Reset
REQ-031 Reset has priority over Pix_Ce.
REQ-032 Reset sets h=v=0, Vid_Addr=VRAM_BASE, prefetch and display bytes to 0, and all 1-bit outputs and Color_Addr to 0.
REQ-033 Reset asserted mid-line or mid-fetch discards the pending capture; the first frame after reset shows line 0, column 0 as zeros, with no error.

Verification
REQ-034 Pix_Ce every 2nd Clock, one full frame -> exactly 320*262 Pix_Ce, one Int_Mid at (0,96), one Int_Vbl at (0,224), 32 Vid_Rd per line.
REQ-035 RAM model, byte at 2400h+5*32+3 = 8'hA5, observe line 5, h=24..31 -> Pixel = 1,0,1,0,0,1,0,1; Color_Addr = 11'h003 on those pixels.
REQ-036 At h=318, v=261 -> Vid_Addr = 16'h2400, Vid_Rd=1; at h=318, v=10 -> Vid_Addr = 16'h2560.
REQ-037 h=256..319 or v>=224 -> Pixel=0, HBlank/VBlank=1; HSync high exactly for h=272..303, VSync for v=236..239.
REQ-038 Reset pulsed at h=150, v=100, one Clock after a Vid_Rd -> the next Clock shows all outputs 0 and HCount=VCount=0, and the prefetch register is 0.
REQ-039 Pix_Ce gaps of 1 and of 5 Clocks randomly mixed -> Pixel stream identical to the fixed-rate run.
